// File: rtl/nios2_ocimem_arbiter.sv
// Arbitrates the Nios II OCI debug RAM between the CPU debug slave and JTAG command strobes.
// Owns MonAReg/MonDReg and sequences single-word JTAG reads/writes with address auto-increment.
module nios2_ocimem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_CPU_ACC, S_JTAG_ACC} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_t;
  typedef enum logic {G_CPU, G_JTAG} grant_t;

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  grant_t              last_q, last_d;
  logic [ADDR_W-1:0]   mon_addr_q, mon_addr_d;
  logic [31:0]         mon_data_q, mon_data_d;
  logic                overrun_q, overrun_d;
  logic                cpu_req, jtag_req, strobe;
  logic                jdo_unused;

  assign jdo_unused   = ^{jdo[37:36], jdo[2:0]};
  assign cpu_req      = cpu_read | cpu_write;
  assign jtag_req     = (op_q != OP_NONE);
  assign strobe       = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign MonDReg      = mon_data_q;
  assign jtag_busy    = jtag_req;
  assign jtag_overrun = overrun_q;
  assign cpu_waitrequest = cpu_req & (state_q != S_CPU_ACC);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    last_d       = last_q;
    mon_addr_d   = mon_addr_q;
    mon_data_d   = mon_data_q;
    overrun_d    = overrun_q;
    ram_addr     = '0;
    ram_wren     = 1'b0;
    ram_byteen   = '0;
    ram_wdata    = '0;
    cpu_readdata = '0;

    // Decode touches op_d only while idle; the FSM touches it only while busy.
    if (strobe) begin
      if (jtag_req) begin
        overrun_d = 1'b1;
      end else if (take_action_ocimem_b) begin
        mon_data_d = jdo[34:3];
        op_d       = OP_WRITE;
      end else if (take_action_ocimem_a) begin
        mon_addr_d = ADDR_W'(jdo[17:10]);
        if (jdo[34]) op_d = OP_READ;
        if (jdo[35]) overrun_d = 1'b0;
      end else begin
        op_d = OP_READ;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req && (!jtag_req || last_q == G_JTAG)) begin
          ram_addr = cpu_address;
          if (cpu_write) begin
            ram_wren   = 1'b1;
            ram_byteen = cpu_byteenable;
            ram_wdata  = cpu_writedata;
          end
          last_d  = G_CPU;
          state_d = S_CPU_ACC;
        end else if (jtag_req) begin
          ram_addr = mon_addr_q;
          if (op_q == OP_WRITE) begin
            ram_wren   = 1'b1;
            ram_byteen = 4'hF;
            ram_wdata  = DATA_W'(mon_data_q);
          end
          last_d  = G_JTAG;
          state_d = S_JTAG_ACC;
        end
      end
      S_CPU_ACC: begin
        cpu_readdata = ram_rdata;
        state_d      = S_IDLE;
      end
      S_JTAG_ACC: begin
        if (op_q == OP_READ) mon_data_d = 32'(ram_rdata);
        mon_addr_d = mon_addr_q + ADDR_W'(1);
        op_d       = OP_NONE;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NONE;
      last_q     <= G_CPU;
      mon_addr_q <= '0;
      mon_data_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      last_q     <= last_d;
      mon_addr_q <= mon_addr_d;
      mon_data_q <= mon_data_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Self-checking bench for nios2_ocimem_arbiter with a behavioural 256x32 RAM and a reference memory.
module tb_nios2_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        ta_a, ta_b, tna_a;
  logic [31:0] MonDReg;
  logic        jtag_busy, jtag_overrun;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  always #5 clk = ~clk;

  nios2_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
    .take_no_action_ocimem_a(tna_a),
    .MonDReg(MonDReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        mem_ready = 1'b0;
  int          wr_count = 0;
  logic [7:0]  last_wr_addr;
  logic [31:0] last_wr_data;
  logic [31:0] cpu_exp_q[$];
  logic [31:0] jtag_exp_q[$];
  logic [7:0]  m_addr;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] pat(input int unsigned i);
    logic [7:0] b;
    b = 8'(i);
    return {8'hA5, b, ~b, b ^ 8'h3C};
  endfunction

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      mem_ready <= 1'b1;
    end else begin
      if (ram_wren) begin
        for (int i = 0; i < 4; i++)
          if (ram_byteen[i]) mem[ram_addr][i*8 +: 8] <= ram_wdata[i*8 +: 8];
        wr_count     <= wr_count + 1;
        last_wr_addr <= ram_addr;
        last_wr_data <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
    end
  end

  function automatic logic [37:0] mk_a(input logic [7:0] a, input logic rd, input logic clr);
    logic [37:0] j;
    j = '0;
    j[17:10] = a;
    j[34] = rd;
    j[35] = clr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, output int waits);
    logic [31:0] exp;
    waits = 0;
    cpu_address = a; cpu_writedata = d; cpu_byteenable = be;
    cpu_read = !wr; cpu_write = wr;
    if (wr) begin
      for (int i = 0; i < 4; i++) if (be[i]) ref_mem[a][i*8 +: 8] = d[i*8 +: 8];
    end else begin
      cpu_exp_q.push_back(ref_mem[a]);
    end
    #1;
    while (cpu_waitrequest && waits < 50) begin
      tick();
      waits++;
      #1;
    end
    checks++;
    if (cpu_waitrequest) begin
      errors++;
      $display("FAIL cpu_timeout addr=%02h waitrequest still high after %0d cycles", a, waits);
      if (!wr) void'(cpu_exp_q.pop_front());
    end else if (!wr) begin
      exp = cpu_exp_q.pop_front();
      checks++;
      if (cpu_readdata !== exp) begin
        errors++;
        $display("FAIL cpu_readdata addr=%02h got=%08h exp=%08h", a, cpu_readdata, exp);
      end
    end
    tick();
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  // s = {b, a, no_action}; held for one cycle
  task automatic jtag_strobe(input logic [2:0] s, input logic [37:0] j);
    {ta_b, ta_a, tna_a} = s;
    jdo = j;
    tick();
    {ta_b, ta_a, tna_a} = 3'b000;
  endtask

  task automatic jtag_wait(output int cycles);
    cycles = 1;
    while (jtag_busy && cycles < 50) begin
      tick();
      cycles++;
    end
    checks++;
    if (jtag_busy) begin
      errors++;
      $display("FAIL jtag_timeout busy still high after %0d cycles", cycles);
    end
  endtask

  task automatic check_mondreg(input string name);
    logic [31:0] exp;
    exp = jtag_exp_q.pop_front();
    checks++;
    if (MonDReg !== exp) begin
      errors++;
      $display("FAIL %s MonDReg got=%08h exp=%08h", name, MonDReg, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    int c;
    do_reset(2);
    checks++;
    if ({MonDReg, jtag_busy, jtag_overrun, ram_wren, ram_addr, cpu_readdata, cpu_waitrequest} !== '0) begin
      errors++;
      $display("FAIL reset_outputs MonDReg=%08h busy=%b ovr=%b wren=%b addr=%02h rdata=%08h wait=%b exp all zero",
               MonDReg, jtag_busy, jtag_overrun, ram_wren, ram_addr, cpu_readdata, cpu_waitrequest);
    end
    reset_n = 1'b1;
    m_addr = 8'h00;
    jtag_exp_q.push_back(ref_mem[m_addr]);
    m_addr++;
    jtag_strobe(3'b001, '0);
    jtag_wait(c);
    check_int("reset_jtag_latency", c, 3);
    check_mondreg("reset_monareg_zero");
  endtask

  task automatic test_cpu_rw();
    int w;
    cpu_access(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, w);
    check_int("cpu_write_wait", w, 1);
    cpu_access(1'b0, 8'h10, '0, 4'h0, w);
    check_int("cpu_read_wait", w, 1);
    cpu_access(1'b1, 8'h10, 32'h11223344, 4'b0101, w);
    cpu_access(1'b0, 8'h10, '0, 4'h0, w);
    check_int("cpu_partial_read_wait", w, 1);
  endtask

  task automatic test_autoinc();
    int c;
    int wc;
    m_addr = 8'hFF;
    jtag_strobe(3'b010, mk_a(8'hFF, 1'b0, 1'b0));
    jtag_wait(c);
    check_int("addr_load_no_busy", c, 1);
    wc = wr_count;
    ref_mem[m_addr] = 32'h12345678;
    m_addr++;
    jtag_strobe(3'b100, mk_b(32'h12345678));
    jtag_wait(c);
    check_int("jtag_write_latency", c, 3);
    check_int("jtag_write_count", wr_count, wc + 1);
    checks++;
    if (last_wr_addr !== 8'hFF || last_wr_data !== 32'h12345678) begin
      errors++;
      $display("FAIL jtag_write_addr_data got=%02h/%08h exp=ff/12345678", last_wr_addr, last_wr_data);
    end
    jtag_exp_q.push_back(ref_mem[m_addr]);
    m_addr++;
    jtag_strobe(3'b001, '0);
    jtag_wait(c);
    check_mondreg("autoinc_wrap_read");
    cpu_access(1'b0, 8'hFF, '0, 4'h0, c);
  endtask

  task automatic test_tie();
    int w;
    int c;
    do_reset(1);
    reset_n = 1'b1;
    m_addr = 8'h00;
    jtag_exp_q.push_back(ref_mem[m_addr]);
    m_addr++;
    jtag_strobe(3'b001, '0);
    fork
      cpu_access(1'b0, 8'h10, '0, 4'h0, w);
      jtag_wait(c);
    join
    check_int("tie1_cpu_wait", w, 3);
    check_int("tie1_jtag_latency", c, 3);
    check_mondreg("tie1_jtag_read");
    // A solo JTAG access leaves last_grant=JTAG, so the next tie favours the CPU.
    jtag_exp_q.push_back(ref_mem[m_addr]);
    m_addr++;
    jtag_strobe(3'b001, '0);
    jtag_wait(c);
    check_mondreg("solo_jtag_read");
    jtag_exp_q.push_back(ref_mem[m_addr]);
    m_addr++;
    jtag_strobe(3'b001, '0);
    fork
      cpu_access(1'b0, 8'hFF, '0, 4'h0, w);
      jtag_wait(c);
    join
    check_int("tie2_cpu_wait", w, 1);
    check_int("tie2_jtag_latency", c, 5);
    check_mondreg("tie2_jtag_read");
  endtask

  task automatic test_overrun();
    int c;
    jtag_exp_q.push_back(ref_mem[m_addr]);
    m_addr++;
    tna_a = 1'b1; jdo = '0;
    tick();
    tick();
    tna_a = 1'b0;
    checks++;
    if (jtag_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got=%b exp=1", jtag_overrun);
    end
    jtag_wait(c);
    check_mondreg("overrun_single_read");
    ref_mem[m_addr] = 32'hCAFEF00D;
    jtag_strobe(3'b100, mk_b(32'hCAFEF00D));
    jtag_wait(c);
    checks++;
    if (last_wr_addr !== m_addr || jtag_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_no_extra_access wr_addr=%02h exp=%02h ovr=%b exp=1",
               last_wr_addr, m_addr, jtag_overrun);
    end
    m_addr++;
    jtag_strobe(3'b010, mk_a(8'h20, 1'b0, 1'b1));
    m_addr = 8'h20;
    checks++;
    if (jtag_overrun !== 1'b0 || jtag_busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear ovr=%b busy=%b exp 0/0", jtag_overrun, jtag_busy);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    jtag_strobe(3'b001, '0);
    tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if (MonDReg !== 32'h0 || jtag_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid MonDReg=%08h busy=%b exp 00000000/0", MonDReg, jtag_busy);
    end
    reset_n = 1'b1;
    m_addr = 8'h00;
    cpu_access(1'b0, 8'h10, '0, 4'h0, w);
    check_int("post_reset_cpu_wait", w, 1);
  endtask

  initial begin
    reset_n = 1'b0; jdo = '0; ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
    cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_writedata = '0; cpu_byteenable = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    tick();
    test_reset();
    test_cpu_rw();
    test_autoinc();
    test_tie();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nios2_ocimem_arbiter.md
# nios2_ocimem_arbiter

Arbitrates the Nios II on-chip debug memory (256×32 OCI RAM, 1-cycle read latency) between two requesters: the CPU's debug-memory Avalon slave port and the JTAG debug slave's `take_action_ocimem_*` command strobes, which arrive already in the `clk` domain. It owns the monitor address and data registers (MonAReg, MonDReg), sequences single-word JTAG reads and writes with address auto-increment, and returns read data to the debug slave shift path.

## Interface
- `ADDR_W`, default 8: OCI RAM word-address width.
- `DATA_W`, default 32: RAM data width. The JTAG data field is fixed at 32 bits.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  reset. **Synchronous, active-low.**
- `jdo`  in  38  JTAG data-out word, valid while any strobe is high.
- `take_action_ocimem_a`  in  1  load address; optionally request a read.
- `take_action_ocimem_b`  in  1  load data; request a write.
- `take_no_action_ocimem_a`  in  1  request a read at the current MonAReg.
- `MonDReg`  out  32  monitor data register, fed to the debug slave capture path.
- `jtag_busy`  out  1  a JTAG request is pending or in flight.
- `jtag_overrun`  out  1  sticky flag: a JTAG strobe arrived while busy.
- `cpu_address`  in  ADDR_W  CPU word address.
- `cpu_read`, `cpu_write`  in  1  CPU request. Held stable while `cpu_waitrequest`=1.
- `cpu_writedata`  in  32  CPU write data.
- `cpu_byteenable`  in  4  CPU write byte enables.
- `cpu_readdata`  out  32  CPU read data, valid when the request is present and `cpu_waitrequest`=0.
- `cpu_waitrequest`  out  1  Avalon waitrequest.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wren`  out  1  RAM write enable.
- `ram_byteen`  out  4  RAM byte enables.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data. Valid one cycle after the address is presented.

## Operation
**JTAG command decode.** Strobes are acted on only when `jtag_busy`=0. If several strobes are high in the same cycle, priority is b > a > no_action, and only the winning strobe is acted on.
- `take_action_ocimem_b`: MonDReg←`jdo[34:3]`; pending op = WRITE.
- `take_action_ocimem_a`: MonAReg←`jdo[17:10]`.
  - If `jdo[34]`=1, pending op = READ.
  - If `jdo[35]`=1, clear `jtag_overrun`.
- `take_no_action_ocimem_a`: pending op = READ at the current MonAReg.
- Any strobe while `jtag_busy`=1 is ignored and sets `jtag_overrun`.

**FSM states:** IDLE, CPU_ACC, JTAG_ACC.
- **IDLE, no requester pending:** all RAM outputs are 0 and the state stays IDLE.
- **IDLE, one requester pending:** that requester is granted.
- **IDLE, both pending:** grant goes to the requester not granted last (`last_grant`).
- **Grant cycle, CPU:** `ram_addr`=`cpu_address`. For a write, `ram_wren`=1, `ram_byteen`=`cpu_byteenable`, `ram_wdata`=`cpu_writedata`. Next state CPU_ACC.
- **Grant cycle, JTAG:** `ram_addr`=MonAReg. For a write, `ram_wren`=1, `ram_byteen`=4'hF, `ram_wdata`=MonDReg. Next state JTAG_ACC.
- **CPU_ACC:** `cpu_waitrequest`=0 and `cpu_readdata`=`ram_rdata`. Return to IDLE.
- **JTAG_ACC:**
  - For a read, MonDReg←`ram_rdata`.
  - MonAReg←MonAReg+1, wrapping from 8'hFF to 8'h00.
  - Clear the pending op and return to IDLE.
- `cpu_waitrequest` = (`cpu_read`|`cpu_write`) & (state≠CPU_ACC). This is combinational.
- `cpu_readdata`=0 outside CPU_ACC.
- `cpu_read` and `cpu_write` are never asserted together. If they are, the request is treated as a write.

## Timing
- **Reset** (`reset_n`=0 at a `clk` edge):
  - State=IDLE, MonAReg=0, MonDReg=0.
  - `jtag_busy`=0, `jtag_overrun`=0.
  - `last_grant`=CPU, so JTAG wins the first tie.
  - `ram_wren`=0, `ram_addr`=0, `cpu_readdata`=0.
- **Reset mid-operation** discards any pending or in-flight op with no acknowledgement. A RAM write presented in the same cycle still lands in the RAM.
- **CPU latency:** a request sampled in IDLE with grant sees `cpu_waitrequest`=0 one cycle later, so the transaction completes in 2 cycles.
- **CPU while JTAG holds the grant:** the CPU request waits 2 more cycles.
- **JTAG latency:** strobe at cycle N sets `jtag_busy` at N+1. The grant comes no earlier than N+1, and MonDReg and MonAReg update at the end of JTAG_ACC. `jtag_busy` falls the cycle after JTAG_ACC, so the best-case JTAG round trip is 3 cycles from the strobe.
- **Back-to-back:** the arbiter returns to IDLE after every access. It sustains one access per 2 cycles, alternating between requesters under contention.

## Test plan
- **Reset values:** hold `reset_n`=0 for 2 cycles with the CPU idle → all outputs at reset values and MonAReg=0.
- **CPU write/read:** CPU write addr 8'h10 data 32'hDEADBEEF with be 4'hF, then read 8'h10 → `cpu_waitrequest` low exactly 1 cycle per access, and `cpu_readdata`=32'hDEADBEEF.
- **JTAG auto-increment:**
  - Send `take_action_ocimem_a` with `jdo[17:10]`=8'hFF and `jdo[34]`=0.
  - Then send `take_action_ocimem_b` with data 32'h12345678, and wait until `jtag_busy`=0.
  - Then send `take_no_action_ocimem_a`.
  - Required response: RAM[8'hFF]=32'h12345678, and MonAReg wraps to 8'h00. The read returns RAM[8'h00] into MonDReg.
- **Tie arbitration:** a CPU read and a JTAG read become pending in the same cycle after reset → JTAG is granted first and the CPU second, each completing correctly. A second tie grants the CPU first.
- **Overrun:**
  - A `take_no_action_ocimem_a` strobe while `jtag_busy`=1 → `jtag_overrun`=1 and no extra RAM access occurs.
  - `take_action_ocimem_a` with `jdo[35]`=1 → `jtag_overrun`=0.
- **Reset mid-JTAG-read:** assert `reset_n`=0 during JTAG_ACC → MonDReg=0, `jtag_busy`=0, and the next CPU read is served normally.
